// File: rtl/axi_pkg.sv
// Shared AXI definitions used across the slice set.
// Only the response encoding is needed by the read-data buffer.
package axi_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_r_buffer.sv
// AXI read-data (R) channel buffer: circular FIFO between the slave-side and
// master-side R ports, with beat and complete-burst occupancy counters.
module axi_r_buffer
  import axi_pkg::*;
#(
  parameter int ID_WIDTH     = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int USER_WIDTH   = 1,
  parameter int BUFFER_DEPTH = 4,
  parameter int CNT_WIDTH    = $clog2(BUFFER_DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  test_en_i,
  input  logic                  slave_valid_i,
  input  logic [ID_WIDTH-1:0]   slave_id_i,
  input  logic [DATA_WIDTH-1:0] slave_data_i,
  input  resp_t                 slave_resp_i,
  input  logic [USER_WIDTH-1:0] slave_user_i,
  input  logic                  slave_last_i,
  output logic                  slave_ready_o,
  output logic                  master_valid_o,
  output logic [ID_WIDTH-1:0]   master_id_o,
  output logic [DATA_WIDTH-1:0] master_data_o,
  output resp_t                 master_resp_o,
  output logic [USER_WIDTH-1:0] master_user_o,
  output logic                  master_last_o,
  input  logic                  master_ready_i,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic [CNT_WIDTH-1:0]  bursts_o
);

  localparam int PTR_W = $clog2(BUFFER_DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(BUFFER_DEPTH);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    resp_t                 resp;
    logic [USER_WIDTH-1:0] user;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } entry_t;

  entry_t               mem_q [BUFFER_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] bursts_q;
  entry_t               wr_entry;
  entry_t               rd_entry;
  logic                 push;
  logic                 pop;
  logic                 push_last;
  logic                 pop_last;

  // Test mode has no functional effect on this buffer.
  logic unused_test_en;
  assign unused_test_en = test_en_i;

  // Handshake: a beat moves on a port in any cycle where valid and ready are
  // both high at the rising edge. Ready/valid here come only from the
  // registered count, so there is no combinational path between the ports.
  assign slave_ready_o  = (count_q != FULL_CNT);
  assign master_valid_o = (count_q != '0);
  assign push           = slave_valid_i & slave_ready_o;
  assign pop            = master_valid_o & master_ready_i;

  assign wr_entry = '{id:   slave_id_i,
                      resp: slave_resp_i,
                      user: slave_user_i,
                      data: slave_data_i,
                      last: slave_last_i};

  assign rd_entry       = mem_q[rd_ptr_q];
  assign master_id_o    = rd_entry.id;
  assign master_resp_o  = rd_entry.resp;
  assign master_user_o  = rd_entry.user;
  assign master_data_o  = rd_entry.data;
  assign master_last_o  = rd_entry.last;

  assign push_last = push & slave_last_i;
  assign pop_last  = pop & master_last_o;

  assign count_o  = count_q;
  assign bursts_o = bursts_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // Pointers wrap on their own since the depth is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q  <= '0;
      bursts_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_WIDTH'(1);
        2'b01:   count_q <= count_q - CNT_WIDTH'(1);
        default: count_q <= count_q;
      endcase
      case ({push_last, pop_last})
        2'b10:   bursts_q <= bursts_q + CNT_WIDTH'(1);
        2'b01:   bursts_q <= bursts_q - CNT_WIDTH'(1);
        default: bursts_q <= bursts_q;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push |-> (count_q != FULL_CNT));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    pop |-> (count_q != '0));
  a_count_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= FULL_CNT);
  a_bursts_le_count: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bursts_q <= count_q);
  a_slave_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (slave_valid_i && !slave_ready_o) |=>
      $stable({slave_id_i, slave_resp_i, slave_user_i, slave_data_i, slave_last_i}));
`endif

endmodule

// File: tb/tb_axi_r_buffer.sv
// Randomised and directed bench for axi_r_buffer, checked against a queue
// model of the FIFO contents.
module tb_axi_r_buffer;
  import axi_pkg::*;

  localparam int IDW   = 4;
  localparam int DW    = 32;
  localparam int UW    = 2;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int BW    = IDW + 2 + UW + DW + 1;

  logic            clk;
  logic            rst_ni;
  logic            test_en_i;
  logic            slave_valid_i;
  logic [IDW-1:0]  slave_id_i;
  logic [DW-1:0]   slave_data_i;
  resp_t           slave_resp_i;
  logic [UW-1:0]   slave_user_i;
  logic            slave_last_i;
  logic            slave_ready_o;
  logic            master_valid_o;
  logic [IDW-1:0]  master_id_o;
  logic [DW-1:0]   master_data_o;
  resp_t           master_resp_o;
  logic [UW-1:0]   master_user_o;
  logic            master_last_o;
  logic            master_ready_i;
  logic [CW-1:0]   count_o;
  logic [CW-1:0]   bursts_o;

  axi_r_buffer #(
    .ID_WIDTH    (IDW),
    .DATA_WIDTH  (DW),
    .USER_WIDTH  (UW),
    .BUFFER_DEPTH(DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .test_en_i     (test_en_i),
    .slave_valid_i (slave_valid_i),
    .slave_id_i    (slave_id_i),
    .slave_data_i  (slave_data_i),
    .slave_resp_i  (slave_resp_i),
    .slave_user_i  (slave_user_i),
    .slave_last_i  (slave_last_i),
    .slave_ready_o (slave_ready_o),
    .master_valid_o(master_valid_o),
    .master_id_o   (master_id_o),
    .master_data_o (master_data_o),
    .master_resp_o (master_resp_o),
    .master_user_o (master_user_o),
    .master_last_o (master_last_o),
    .master_ready_i(master_ready_i),
    .count_o       (count_o),
    .bursts_o      (bursts_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [BW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  logic was_pushed;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_bursts();
    int n = 0;
    foreach (exp_q[i]) n += int'(exp_q[i][0]);
    return n;
  endfunction

  // One clock: compare DUT outputs with the model mid-cycle, then advance
  // the model by the transfers the model itself says happen at the edge.
  task automatic step();
    logic          push;
    logic          pop;
    logic [BW-1:0] in_beat;
    logic [BW-1:0] out_beat;
    @(negedge clk);
    out_beat = {master_id_o, master_resp_o, master_user_o, master_data_o, master_last_o};
    check("valid",  64'(master_valid_o), 64'(exp_q.size() != 0));
    check("ready",  64'(slave_ready_o),  64'(exp_q.size() != DEPTH));
    check("count",  64'(count_o),        64'(exp_q.size()));
    check("bursts", 64'(bursts_o),       64'(model_bursts()));
    if (exp_q.size() != 0) check("payload", 64'(out_beat), 64'(exp_q[0]));
    push    = slave_valid_i && (exp_q.size() != DEPTH);
    pop     = master_ready_i && (exp_q.size() != 0);
    in_beat = {slave_id_i, slave_resp_i, slave_user_i, slave_data_i, slave_last_i};
    @(posedge clk);
    if (!rst_ni) begin
      exp_q.delete();
      was_pushed = 1'b0;
    end else begin
      if (pop)  void'(exp_q.pop_front());
      if (push) exp_q.push_back(in_beat);
      was_pushed = push;
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_beat(input logic [IDW-1:0] id, input resp_t resp,
                          input logic [UW-1:0] user, input logic [DW-1:0] data,
                          input logic last);
    slave_valid_i = 1'b1;
    slave_id_i    = id;
    slave_resp_i  = resp;
    slave_user_i  = user;
    slave_data_i  = data;
    slave_last_i  = last;
  endtask

  task automatic set_random_beat();
    set_beat(IDW'($urandom), resp_t'($urandom_range(3, 0)), UW'($urandom),
             DW'($urandom), 1'($urandom_range(1, 0)));
  endtask

  task automatic drain();
    slave_valid_i  = 1'b0;
    master_ready_i = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) step();
    master_ready_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int sent;
    int cyc;
    rst_ni         = 1'b0;
    test_en_i      = 1'b0;
    slave_valid_i  = 1'b0;
    slave_id_i     = '0;
    slave_data_i   = '0;
    slave_resp_i   = RESP_OKAY;
    slave_user_i   = '0;
    slave_last_i   = 1'b0;
    master_ready_i = 1'b0;
    was_pushed     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;

    // Reset state, idle
    check("rst_data", 64'(master_data_o), 64'd0);
    check("rst_valid", 64'(master_valid_o), 64'd0);
    check("rst_ready", 64'(slave_ready_o), 64'd1);
    step();
    step();

    // Single beat held while master stalls
    set_beat(4'd5, RESP_OKAY, 2'd1, 32'hA5A5_A5A5, 1'b1);
    step();
    slave_valid_i = 1'b0;
    check("single_count", 64'(count_o), 64'd1);
    check("single_bursts", 64'(bursts_o), 64'd1);
    check("single_data", 64'(master_data_o), 64'hA5A5_A5A5);
    repeat (5) step();
    check("single_hold", 64'(master_id_o), 64'd5);
    master_ready_i = 1'b1;
    step();
    master_ready_i = 1'b0;
    check("single_empty", 64'(count_o), 64'd0);
    step();

    // Fill to full, stall, one pop frees a slot
    for (int i = 0; i < 4; i++) begin
      set_beat(IDW'(i), RESP_OKAY, 2'd0, DW'(32'h100 + i), i == 3);
      step();
    end
    check("full_ready", 64'(slave_ready_o), 64'd0);
    check("full_count", 64'(count_o), 64'd4);
    check("full_bursts", 64'(bursts_o), 64'd1);
    set_beat(4'd4, RESP_EXOKAY, 2'd0, 32'h104, 1'b0);
    step();
    step();
    master_ready_i = 1'b1;
    step();
    master_ready_i = 1'b0;
    check("pop_ready", 64'(slave_ready_o), 64'd1);
    step();
    check("beat5_in", 64'(was_pushed), 64'd1);
    set_beat(4'd5, RESP_OKAY, 2'd0, 32'h105, 1'b1);
    step();
    check("beat6_stall", 64'(was_pushed), 64'd0);
    drain();

    // Continuous streaming, full throughput across pointer wrap
    master_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_beat(IDW'(i), RESP_OKAY, UW'(i), DW'(i), (i % 4) == 3);
      step();
      check("stream_push", 64'(was_pushed), 64'd1);
    end
    check("stream_count", 64'(count_o), 64'd1);
    drain();

    // Simultaneous push/pop of LAST beats at count 2, error responses
    set_beat(4'd1, RESP_SLVERR, 2'd1, 32'hDEAD_0001, 1'b1);
    step();
    set_beat(4'd2, RESP_DECERR, 2'd2, 32'hDEAD_0002, 1'b1);
    step();
    set_beat(4'd3, RESP_OKAY, 2'd3, 32'hDEAD_0003, 1'b1);
    master_ready_i = 1'b1;
    step();
    check("sim_count", 64'(count_o), 64'd2);
    check("sim_bursts", 64'(bursts_o), 64'd2);
    check("sim_resp", 64'(master_resp_o), 64'(RESP_DECERR));
    drain();

    // Reset while holding beats
    for (int i = 0; i < 3; i++) begin
      set_beat(IDW'(i + 8), RESP_EXOKAY, 2'd3, DW'(32'hFFFF_0000 + i), i == 1);
      step();
    end
    slave_valid_i = 1'b0;
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    check("mid_rst_count", 64'(count_o), 64'd0);
    check("mid_rst_bursts", 64'(bursts_o), 64'd0);
    check("mid_rst_data", 64'(master_data_o), 64'd0);
    step();

    // Random valid/ready over 1000 beats
    sent = 0;
    cyc  = 0;
    slave_valid_i = 1'b0;
    while ((sent < 1000 || exp_q.size() != 0) && cyc < 20000) begin
      if (!slave_valid_i && sent < 1000 && $urandom_range(1, 0) == 1) set_random_beat();
      master_ready_i = 1'($urandom_range(1, 0));
      step();
      if (was_pushed) begin
        sent++;
        slave_valid_i = 1'b0;
      end
      cyc++;
    end
    check("rand_done", 64'((sent == 1000) && (exp_q.size() == 0)), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_r_buffer.md
Name: axi_r_buffer

Overview:
- Read-data (R) channel buffer: the return-direction counterpart of the write-data buffer in the AXI slice set.
- Accepts R beats from the slave-side port and re-issues them on the master-side port.
- Storage is a BUFFER_DEPTH-entry circular FIFO.
- Tracks buffered beat count and the number of complete bursts held; the slice wrapper uses these for burst-aware back-pressure and debug.

Parameters:
ID_WIDTH, -1, width of RID (must be overridden, >=1)
DATA_WIDTH, -1, width of RDATA (must be overridden, >=8)
USER_WIDTH, -1, width of RUSER (must be overridden, >=1)
BUFFER_DEPTH, -1, FIFO entries; power of two, >=2 (must be overridden)
CNT_WIDTH, $clog2(BUFFER_DEPTH)+1, derived, do not override

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
test_en_i  in  1  test mode; no functional effect, kept for slice uniformity
slave_valid_i  in  1  RVALID from slave side
slave_id_i  in  ID_WIDTH  RID
slave_data_i  in  DATA_WIDTH  RDATA
slave_resp_i  in  2  RRESP
slave_user_i  in  USER_WIDTH  RUSER
slave_last_i  in  1  RLAST
slave_ready_o  out  1  RREADY to slave side
master_valid_o  out  1  RVALID to master side
master_id_o  out  ID_WIDTH  RID
master_data_o  out  DATA_WIDTH  RDATA
master_resp_o  out  2  RRESP
master_user_o  out  USER_WIDTH  RUSER
master_last_o  out  1  RLAST
master_ready_i  in  1  RREADY from master side
count_o  out  CNT_WIDTH  beats currently stored
bursts_o  out  CNT_WIDTH  complete bursts (LAST beats) currently stored

Behaviour:
- All state updates on rising clk_i. While rst_ni==0 at an edge:
  - wr_ptr, rd_ptr, count, bursts all go to 0.
  - All storage entries are cleared to 0.
- Resulting reset output values:
  - master_valid_o=0, all master_* payload=0.
  - slave_ready_o=1 (BUFFER_DEPTH>=2, so not full).
  - count_o=0, bursts_o=0.
- Reset asserted mid-burst discards all stored beats. No partial-burst recovery.
- push = slave_valid_i & slave_ready_o. pop = master_valid_o & master_ready_i.
- slave_ready_o = (count != BUFFER_DEPTH). Combinational from registered count only; never depends on slave_valid_i.
- master_valid_o = (count != 0). Payload is driven combinationally from entry[rd_ptr].
- Latency: a beat pushed at edge N is visible on master_* in the cycle after edge N. There is no combinational input-to-output bypass, even when empty.
- AXI stability: while master_valid_o=1 and master_ready_i=0, all master_* outputs are held.
- Entry format is {id, resp, user, data, last}, written at wr_ptr on push.
- Pointers are $clog2(BUFFER_DEPTH) bits and wrap modulo BUFFER_DEPTH naturally.
- count update:
  - push only: +1.
  - pop only: -1.
  - push and pop: unchanged, and both pointers advance.
- Full (count==BUFFER_DEPTH): slave_ready_o=0, so no push. A pop in that cycle gives count=BUFFER_DEPTH-1 and ready=1 in the next cycle. No same-cycle fall-through.
- Empty (count==0): master_valid_o=0, so no pop. master_ready_i is ignored.
- bursts update:
  - +1 on push with slave_last_i=1.
  - -1 on pop with master_last_o=1.
  - Both in the same cycle: unchanged.
  - bursts <= count always holds.
- Beats are never reordered, dropped, or modified. Interleaved IDs pass through in arrival order.
- RRESP values (OKAY/EXOKAY/SLVERR/DECERR) pass through untouched.
- Assertions (sim only):
  - No push when full; no pop when empty.
  - count <= BUFFER_DEPTH.
  - slave_* payload stable while slave_valid_i & !slave_ready_o.

Decomposition:
- axi_pkg (existing shared package) holds the resp_t 2-bit typedef and the RESP_OKAY/EXOKAY/SLVERR/DECERR constants; ports use resp_t.
- A local packed struct for the entry is defined inside the module, not in the package.
- No sub-module: storage array, pointers and counters live in this module. It is a standalone buffer, not a wrapper over axi_single_slice.

Test Plan:
- Reset, then idle:
  - -> master_valid_o=0, slave_ready_o=1, count_o=0, bursts_o=0, master_data_o=0.
  - Assert rst_ni=0 for one edge while holding 3 beats -> all counters 0 next cycle.
- DEPTH=4, push single beat id=5, data=0xA5A5A5A5, resp=OKAY, last=1 at edge N, master_ready_i=0:
  - master_valid_o=1 after edge N, count_o=1, bursts_o=1.
  - Payload held for 5 cycles unchanged.
  - Then ready=1 -> popped, count_o=0, bursts_o=0.
- DEPTH=4, push 6 beats back-to-back (burst of 4 with last on beat 4, then 2 beats) with master_ready_i=0:
  - After 4 pushes: slave_ready_o=0, count_o=4, bursts_o=1.
  - Beats 5 and 6 are stalled.
  - One pop -> slave_ready_o=1 next cycle; beat 5 accepted.
- Continuous streaming, slave_valid_i=1 and master_ready_i=1 for 20 cycles, data=incrementing, last every 4th beat:
  - Output sequence identical, one-cycle latency, full throughput.
  - count_o steady at 1 after the first beat.
  - Pointer wrap exercised (20 > DEPTH).
- Simultaneous push/pop with count=2 where the pushed beat has last=1 and the popped beat has last=1:
  - count_o stays 2, bursts_o unchanged.
  - RRESP=SLVERR and DECERR beats emerge unaltered in order.
- Random valid/ready (50%) over 1000 beats with random id/resp/user:
  - Scoreboard shows no loss, duplication or reordering.
  - bursts_o always equals LAST beats pushed minus LAST beats popped.
